// File: rtl/map_mem_seq.sv
// map_mem_seq: sequences one external 8-bit SRAM/PSRAM access per CPU M2 cycle.
// Defining MAP_MEM_SEQ_STAT_EN adds the ovr_cnt/acc_cnt statistics outputs.

module map_mem_seq #(
  parameter int unsigned ADDR_DLY = 2,
  parameter int unsigned RD_CYC   = 4,
  parameter int unsigned WR_DLY   = 3,
  parameter int unsigned WR_CYC   = 3,
  parameter logic [5:0]  SRM_BASE = 6'b100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic        cpu_rw,
  input  logic        prg_ce,
  input  logic        prg_we,
  input  logic [22:0] prg_addr,
  input  logic        srm_ce,
  input  logic        srm_we,
  input  logic [17:0] srm_addr,
  input  logic [7:0]  dati,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_do,
  input  logic [7:0]  mem_di,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we
`ifdef MAP_MEM_SEQ_STAT_EN
  ,
  output logic [15:0] ovr_cnt,
  output logic [15:0] acc_cnt
`endif
);

  // state  | meaning
  // IDLE   | waiting for synchronized M2 rise
  // SETTLE | letting the CPU address/rw settle; M2 fall here aborts
  // READ   | mem_ce/mem_oe asserted, data captured on last cycle
  // WDLY   | waiting for CPU write data to become valid
  // WRITE  | mem_ce/mem_we asserted with stable address and data
  // DONE   | access finished, waiting for M2 low
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_WDLY   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_DLY - 1);
  localparam logic [3:0] RD_LAST   = 4'(RD_CYC - 1);
  localparam logic [3:0] WDLY_LAST = 4'(WR_DLY - 1);
  localparam logic [3:0] WR_LAST   = 4'(WR_CYC - 1);

  logic [2:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        m2_s1, m2_s2, m2_s3;
  logic        m2_rise, m2_fall;
  logic        sel_any, wr_en;
  logic [23:0] addr_sel;
  logic [23:0] addr_nxt;
  logic [7:0]  do_nxt;
  logic [7:0]  rd_nxt;
  logic        rdv_nxt;

  // Edge pulses are registered so they land 3 clk after the pin edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_s1   <= 1'b0;
      m2_s2   <= 1'b0;
      m2_s3   <= 1'b0;
      m2_rise <= 1'b0;
      m2_fall <= 1'b0;
    end else begin
      m2_s1   <= m2;
      m2_s2   <= m2_s1;
      m2_s3   <= m2_s2;
      m2_rise <= m2_s2 & ~m2_s3;
      m2_fall <= ~m2_s2 & m2_s3;
    end
  end

  // SRM wins when both windows decode; write permission follows the winner.
  assign sel_any  = srm_ce | prg_ce;
  assign wr_en    = srm_ce ? srm_we : (prg_ce & prg_we);
  assign addr_sel = srm_ce ? {SRM_BASE, srm_addr} : {1'b0, prg_addr};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = mem_addr;
    do_nxt    = mem_do;
    rd_nxt    = rd_data;
    rdv_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m2_rise) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = 4'd0;
        end
      end
      ST_SETTLE: begin
        if (m2_fall) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == ADDR_LAST) begin
          cnt_nxt = 4'd0;
          if (sel_any) addr_nxt = addr_sel;
          if (cpu_rw && sel_any) begin
            state_nxt = ST_READ;
          end else if (!cpu_rw && wr_en) begin
            if (WR_DLY == 0) begin
              do_nxt    = dati;
              state_nxt = ST_WRITE;
            end else begin
              state_nxt = ST_WDLY;
            end
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_READ: begin
        if (cnt == RD_LAST) begin
          rd_nxt    = mem_di;
          rdv_nxt   = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_WDLY: begin
        if (cnt == WDLY_LAST) begin
          do_nxt    = dati;
          cnt_nxt   = 4'd0;
          state_nxt = ST_WRITE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_WRITE: begin
        if (cnt == WR_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_DONE: begin
        if (!m2_s2) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      mem_addr <= 24'd0;
      mem_do   <= 8'd0;
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mem_addr <= addr_nxt;
      mem_do   <= do_nxt;
      rd_data  <= rd_nxt;
      rd_valid <= rdv_nxt;
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign busy   = (state != ST_IDLE);
  assign mem_oe = (state == ST_READ);
  assign mem_we = (state == ST_WRITE);
  assign mem_ce = mem_oe | mem_we;

`ifdef MAP_MEM_SEQ_STAT_EN
  logic ovr_evt;
  logic acc_evt;

  assign ovr_evt = m2_rise & ((state == ST_READ) | (state == ST_WDLY) | (state == ST_WRITE));
  assign acc_evt = ((state == ST_READ) && (cnt == RD_LAST)) ||
                   ((state == ST_WRITE) && (cnt == WR_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= 16'd0;
      acc_cnt <= 16'd0;
    end else begin
      if (ovr_evt && (ovr_cnt != 16'hFFFF)) ovr_cnt <= ovr_cnt + 16'd1;
      if (acc_evt) acc_cnt <= acc_cnt + 16'd1;
    end
  end
`else
  // statistics counters not built
`endif

endmodule

// File: tb/tb_map_mem_seq.sv
// Scoreboard bench for map_mem_seq: stimulus queues expected accesses/reads,
// a negedge monitor pops and compares them as the DUT produces them.

module tb_map_mem_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic        prg_ce = 1'b0;
  logic        prg_we = 1'b0;
  logic [22:0] prg_addr = '0;
  logic        srm_ce = 1'b0;
  logic        srm_we = 1'b0;
  logic [17:0] srm_addr = '0;
  logic [7:0]  dati = '0;
  logic [7:0]  mem_di = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_do;
  logic        mem_ce;
  logic        mem_oe;
  logic        mem_we;
`ifdef MAP_MEM_SEQ_STAT_EN
  logic [15:0] ovr_cnt;
  logic [15:0] acc_cnt;
`endif

  map_mem_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m2       (m2),
    .cpu_rw   (cpu_rw),
    .prg_ce   (prg_ce),
    .prg_we   (prg_we),
    .prg_addr (prg_addr),
    .srm_ce   (srm_ce),
    .srm_we   (srm_we),
    .srm_addr (srm_addr),
    .dati     (dati),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_do   (mem_do),
    .mem_di   (mem_di),
    .mem_ce   (mem_ce),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we)
`ifdef MAP_MEM_SEQ_STAT_EN
    ,
    .ovr_cnt  (ovr_cnt),
    .acc_cnt  (acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [7:0]  data;
    int          width;
  } acc_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_t;

  acc_t acc_q[$];
  rd_t  rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_acc(input bit wr, input logic [23:0] a, input logic [7:0] d, input int w);
    acc_t e;
    e.wr = wr; e.addr = a; e.data = d; e.width = w;
    acc_q.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] d, input int c);
    rd_t r;
    r.data = d; r.cyc = c;
    rd_q.push_back(r);
  endtask

  // Monitor: one record per mem_ce pulse, one pop per rd_valid pulse.
  logic        in_acc = 1'b0;
  int          width;
  logic        a_oe, a_we;
  logic [23:0] a_addr;
  logic [7:0]  a_do;
  logic        unstable;
  acc_t        e_acc;
  rd_t         e_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_acc = 1'b0;
    end else begin
      if (mem_ce) begin
        if (!in_acc) begin
          in_acc = 1'b1; width = 0; a_oe = mem_oe; a_we = mem_we;
          a_addr = mem_addr; a_do = mem_do; unstable = 1'b0;
        end
        width++;
        if (mem_oe !== a_oe || mem_we !== a_we || mem_addr !== a_addr ||
            mem_do !== a_do || (mem_oe && mem_we)) unstable = 1'b1;
      end else if (in_acc) begin
        in_acc = 1'b0;
        acc_seen++;
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_access: got access at %h, expected none", a_addr);
        end else begin
          e_acc = acc_q.pop_front();
          chk("acc_kind", 32'({a_oe, a_we}), e_acc.wr ? 32'h1 : 32'h2);
          chk("acc_addr", 32'(a_addr), 32'(e_acc.addr));
          chk("acc_width", 32'(width), 32'(e_acc.width));
          if (e_acc.wr) chk("wr_data", 32'(a_do), 32'(e_acc.data));
          chk("acc_stable", 32'(unstable), 32'h0);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_valid: got rd_data %h, expected no pulse", rd_data);
        end else begin
          e_rd = rd_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e_rd.data));
          chk("rd_latency", 32'(cyc), 32'(e_rd.cyc));
        end
      end
    end
  end

  task automatic pulse(input int hi, input int lo);
    repeat (hi) @(posedge clk);
    #1 m2 = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  int base;
  int n;

  initial begin
    #3;
    chk("reset_mem_ce", 32'(mem_ce), 32'h0);
    chk("reset_mem_oe", 32'(mem_oe), 32'h0);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_mem_do", 32'(mem_do), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // PRG read
    cpu_rw = 1'b1; prg_ce = 1'b1; prg_we = 1'b0; srm_ce = 1'b0;
    prg_addr = 23'h000123; mem_di = 8'hA5;
    @(posedge clk); #1 m2 = 1'b1;
    push_acc(1'b0, 24'h000123, 8'h00, 4);
    push_rd(8'hA5, cyc + 10);
    pulse(12, 8);
    chk("read_busy_idle", 32'(busy), 32'h0);

    // SRM write
    cpu_rw = 1'b0; prg_ce = 1'b0; srm_ce = 1'b1; srm_we = 1'b1;
    srm_addr = 18'h01FFF; dati = 8'h3C;
    @(posedge clk); #1 m2 = 1'b1;
    push_acc(1'b1, 24'h801FFF, 8'h3C, 3);
    pulse(12, 8);
    chk("write_rd_hold", 32'(rd_data), 32'hA5);
    chk("write_addr_hold", 32'(mem_addr), 32'h801FFF);

    // write to PRG without write enable: no access
    srm_ce = 1'b0; srm_we = 1'b0; prg_ce = 1'b1; prg_we = 1'b0; cpu_rw = 1'b0;
    base = acc_seen;
    @(posedge clk); #1 m2 = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) chk("noacc_busy_high", 32'(busy), 32'h1);
    repeat (4) @(posedge clk);
    #1 m2 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) chk("noacc_busy_low", 32'(busy), 32'h0);
    chk("noacc_count", 32'(acc_seen), 32'(base));

    // 2-clk M2 glitch
    cpu_rw = 1'b1;
    base = acc_seen;
    @(posedge clk); #1 m2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 m2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("glitch_settle_busy", 32'(busy), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk) chk("glitch_idle_busy", 32'(busy), 32'h0);
    repeat (10) @(posedge clk);
    chk("glitch_count", 32'(acc_seen), 32'(base));

    // both windows selected: SRM takes priority
    srm_ce = 1'b1; prg_ce = 1'b1; cpu_rw = 1'b1;
    srm_addr = 18'h3FFFF; mem_di = 8'h96;
    @(posedge clk); #1 m2 = 1'b1;
    push_acc(1'b0, 24'h83FFFF, 8'h00, 4);
    push_rd(8'h96, cyc + 10);
    pulse(12, 8);

    // overrun: second M2 rise lands during READ and is dropped
    srm_ce = 1'b0; prg_ce = 1'b1; cpu_rw = 1'b1;
    prg_addr = 23'h7FFFFF; mem_di = 8'h5A;
    base = acc_seen;
    @(posedge clk); #1 m2 = 1'b1;
    push_acc(1'b0, 24'h7FFFFF, 8'h00, 4);
    push_rd(8'h5A, cyc + 10);
    repeat (4) @(posedge clk);
    #1 m2 = 1'b0;
    @(posedge clk); #1 m2 = 1'b1;
    pulse(10, 10);
    chk("overrun_count", 32'(acc_seen), 32'(base + 1));
    chk("overrun_busy", 32'(busy), 32'h0);
`ifdef MAP_MEM_SEQ_STAT_EN
    chk("stat_ovr", 32'(ovr_cnt), 32'h1);
    chk("stat_acc", 32'(acc_cnt), 32'h4);
`endif

    // reset in the middle of a write pulse
    cpu_rw = 1'b0; prg_ce = 1'b0; srm_ce = 1'b1; srm_we = 1'b1;
    srm_addr = 18'h00010; dati = 8'hE7;
    @(posedge clk); #1 m2 = 1'b1;
    n = 0;
    while (!mem_we && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rst_we_seen", 32'(mem_we), 32'h1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_ce", 32'(mem_ce), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    m2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef MAP_MEM_SEQ_STAT_EN
    chk("stat_ovr_rst", 32'(ovr_cnt), 32'h0);
    chk("stat_acc_rst", 32'(acc_cnt), 32'h0);
`endif
    repeat (3) @(posedge clk);

    // normal read after reset
    srm_ce = 1'b0; srm_we = 1'b0; prg_ce = 1'b1; cpu_rw = 1'b1;
    prg_addr = 23'h000001; mem_di = 8'h11;
    @(posedge clk); #1 m2 = 1'b1;
    push_acc(1'b0, 24'h000001, 8'h00, 4);
    push_rd(8'h11, cyc + 10);
    pulse(12, 8);
    chk("post_rst_rd_data", 32'(rd_data), 32'h11);
`ifdef MAP_MEM_SEQ_STAT_EN
    chk("stat_acc_post", 32'(acc_cnt), 32'h1);
`endif

    chk("acc_queue_empty", 32'(acc_q.size()), 32'h0);
    chk("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout at %0d cycles, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
